// File: rtl/jump_hazard_ctrl.sv
// jump_hazard_ctrl: decode-stage control-hazard controller for jump_unit.
// Tracks destination registers of the instructions in EX, MEM and WB.
// From them it derives the branch operand forwarding selects and the
// load-use stall. Taken branches and jumps become a PC redirect plus an
// IF/ID flush. Saturating counters record redirects and stalls.
module jump_hazard_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             br_en,
    input  logic             jal_en,
    input  logic             jalr_en,
    input  logic [XLEN-1:0]  jalr_PC,
    output logic [2:0]       forward_jump_operand1,
    output logic [2:0]       forward_jump_operand2,
    output logic             stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Scoreboard entries: _p0 = EX, _p1 = MEM, _p2 = WB
    logic       ex_v_p0, mem_v_p1, wb_v_p2;
    logic [4:0] ex_rd_p0, mem_rd_p1, wb_rd_p2;
    logic       ex_ld_p0, mem_ld_p1;

    logic uses_rs1, uses_rs2, writer, is_load;
    logic haz_rs1, haz_rs2, adv, take;

    // Operand select with EX > MEM > WB priority. A load still in EX has no
    // value to forward yet, so it yields the register-file select; the stall
    // covers that case and the nearest producer still shadows older ones.
    function automatic logic [2:0] fwd_sel(
        input logic [4:0] rs,
        input logic       ex_v,
        input logic [4:0] ex_rd,
        input logic       ex_ld,
        input logic       mem_v,
        input logic [4:0] mem_rd,
        input logic       mem_ld,
        input logic       wb_v,
        input logic [4:0] wb_rd
    );
        logic [2:0] sel;
        sel = 3'd0;
        if (rs != 5'd0) begin
            if (ex_v && (ex_rd == rs))
                sel = ex_ld ? 3'd0 : 3'd1;
            else if (mem_v && (mem_rd == rs))
                sel = mem_ld ? 3'd3 : 3'd2;
            else if (wb_v && (wb_rd == rs))
                sel = 3'd4;
        end
        return sel;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Decode classification, forwarding selects, hazard and redirect decision.
    always_comb begin
        uses_rs1 = (id_opcode == OP_BR) || (id_opcode == OP_JALR);
        uses_rs2 = (id_opcode == OP_BR);
        is_load  = (id_opcode == OP_LOAD);
        writer   = (id_opcode != OP_BR) && (id_opcode != OP_STORE) && (id_rd != 5'd0);

        forward_jump_operand1 = uses_rs1 ?
            fwd_sel(id_rs1, ex_v_p0, ex_rd_p0, ex_ld_p0, mem_v_p1, mem_rd_p1,
                    mem_ld_p1, wb_v_p2, wb_rd_p2) : 3'd0;
        forward_jump_operand2 = uses_rs2 ?
            fwd_sel(id_rs2, ex_v_p0, ex_rd_p0, ex_ld_p0, mem_v_p1, mem_rd_p1,
                    mem_ld_p1, wb_v_p2, wb_rd_p2) : 3'd0;

        haz_rs1 = uses_rs1 && (id_rs1 != 5'd0) && ex_v_p0 && ex_ld_p0 && (ex_rd_p0 == id_rs1);
        haz_rs2 = uses_rs2 && (id_rs2 != 5'd0) && ex_v_p0 && ex_ld_p0 && (ex_rd_p0 == id_rs2);
        stall   = id_valid && (haz_rs1 || haz_rs2);
        adv     = id_valid && !stall;
        take    = adv && (br_en || jal_en || jalr_en);

        redirect_valid = take;
        flush          = take;
        redirect_pc    = '0;
        if (take)
            redirect_pc = jalr_en ? {jalr_PC[XLEN-1:1], 1'b0} : (id_pc + imm);
    end

    // Scoreboard valid bits and event counters; reset clears every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_p0   <= 1'b0;
            mem_v_p1  <= 1'b0;
            wb_v_p2   <= 1'b0;
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            ex_v_p0  <= adv && writer;
            mem_v_p1 <= ex_v_p0;
            wb_v_p2  <= mem_v_p1;
            if (take)
                taken_cnt <= sat_inc(taken_cnt);
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // Scoreboard register index and load flag; only meaningful when valid.
    always_ff @(posedge clk) begin
        ex_rd_p0  <= id_rd;
        ex_ld_p0  <= is_load;
        mem_rd_p1 <= ex_rd_p0;
        mem_ld_p1 <= ex_ld_p0;
        wb_rd_p2  <= mem_rd_p1;
    end

endmodule
